// File: rtl/debug_bus_responder.sv
// Memory-bus stand-in for core bring-up: answers strobe/writeEnable transactions after
// WAIT_STATES cycles, folds writes into an LED-visible signature and conditions an IRQ line.
module debug_bus_responder #(
  parameter int unsigned          ADDRESS_SIZE = 15,
  parameter int unsigned          DATA_SIZE    = 32,
  parameter int unsigned          WAIT_STATES  = 2,
  parameter logic [DATA_SIZE-1:0] GEN_STEP     = DATA_SIZE'(32'h9E3779B9),
  parameter int unsigned          IRQ_SIZE     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_SIZE-1:0] address,
  input  logic [DATA_SIZE-1:0]    dataWrite,
  input  logic                    writeEnable,
  input  logic                    strobe,
  output logic [DATA_SIZE-1:0]    dataRead,
  output logic                    ready,
  input  logic                    mode,
  input  logic                    displayStep,
  output logic [7:0]              bits,
  output logic [DATA_SIZE-1:0]    signature,
  output logic [15:0]             txnCount,
  input  logic                    irqSource,
  output logic [IRQ_SIZE-1:0]     interruptReq,
  output logic [1:0]              state_dbg
);

  // Handshake: the master raises strobe and holds it until ready; ready is a one-cycle
  // pulse, and a new transaction is only accepted after strobe has been seen low again.
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_DONE} state_e;

  localparam int unsigned          BYTES     = DATA_SIZE / 8;
  localparam int unsigned          IDX_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(BYTES - 1);
  localparam logic [3:0]           WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  function automatic logic [DATA_SIZE-1:0] rotl8(input logic [DATA_SIZE-1:0] x);
    return {x[DATA_SIZE-9:0], x[DATA_SIZE-1:DATA_SIZE-8]};
  endfunction

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0]    wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    mode_q, mode_d;
  logic                    ready_q, ready_d;
  logic [DATA_SIZE-1:0]    rdata_q, rdata_d;
  logic [DATA_SIZE-1:0]    sig_q, sig_d;
  logic [DATA_SIZE-1:0]    last_q, last_d;
  logic [DATA_SIZE-1:0]    gen_q, gen_d;
  logic [15:0]             txn_q, txn_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7:0]              bits_q, bits_d;
  logic                    step_prev_q, step_prev_d;
  logic [IRQ_SIZE-1:0]     irq_q, irq_d;

  logic                    enter_resp;
  logic [ADDRESS_SIZE-1:0] txn_addr;
  logic [DATA_SIZE-1:0]    txn_wdata;
  logic                    txn_we;
  logic                    txn_mode;
  logic [DATA_SIZE-1:0]    addr_ext;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    mode_d      = mode_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    sig_d       = sig_q;
    last_d      = last_q;
    gen_d       = gen_q;
    txn_d       = txn_q;
    idx_d       = idx_q;
    step_prev_d = displayStep;
    enter_resp  = 1'b0;

    // With zero wait states the transaction completes on its acceptance edge, so the
    // live inputs stand in for the not-yet-latched copies.
    txn_addr  = (state_q == ST_IDLE) ? address     : addr_q;
    txn_wdata = (state_q == ST_IDLE) ? dataWrite   : wdata_q;
    txn_we    = (state_q == ST_IDLE) ? writeEnable : we_q;
    txn_mode  = (state_q == ST_IDLE) ? mode        : mode_q;
    addr_ext  = DATA_SIZE'(txn_addr);

    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          addr_d  = address;
          wdata_d = dataWrite;
          we_d    = writeEnable;
          mode_d  = mode;
          if (WAIT_STATES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_DONE;
      ST_DONE: if (!strobe) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      ready_d = 1'b1;
      if (txn_q != 16'hFFFF) txn_d = txn_q + 16'd1;
      if (txn_we) begin
        sig_d  = rotl8(sig_q) ^ txn_wdata ^ addr_ext;
        last_d = txn_wdata;
      end else if (txn_mode) begin
        rdata_d = last_q;
      end else begin
        rdata_d = gen_q ^ addr_ext;
        gen_d   = rotl8(gen_q) + GEN_STEP;
      end
    end

    if (displayStep && !step_prev_q) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    bits_d = ~sig_q[8*idx_q +: 8];
  end

  generate
    if (IRQ_SIZE == 1) begin : g_irq_single
      assign irq_d = irqSource;
    end else begin : g_irq_shift
      assign irq_d = {irq_q[IRQ_SIZE-2:0], irqSource};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      mode_q      <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      sig_q       <= '0;
      last_q      <= '0;
      gen_q       <= '0;
      txn_q       <= '0;
      idx_q       <= '0;
      bits_q      <= 8'hFF;
      step_prev_q <= 1'b0;
      irq_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      mode_q      <= mode_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      sig_q       <= sig_d;
      last_q      <= last_d;
      gen_q       <= gen_d;
      txn_q       <= txn_d;
      idx_q       <= idx_d;
      bits_q      <= bits_d;
      step_prev_q <= step_prev_d;
      irq_q       <= irq_d;
    end
  end

  assign dataRead     = rdata_q;
  assign ready        = ready_q;
  assign bits         = bits_q;
  assign signature    = sig_q;
  assign txnCount     = txn_q;
  assign interruptReq = irq_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_debug_bus_responder.sv
// Bench for debug_bus_responder: directed scenarios plus random transactions, checked by a
// scoreboard fed from a behavioural model of the read generator, signature and counter.
module tb_debug_bus_responder;

  localparam int unsigned AW   = 15;
  localparam int unsigned DW   = 32;
  localparam int unsigned WS   = 2;
  localparam int unsigned IRQW = 2;
  localparam int unsigned NB   = DW / 8;
  localparam logic [DW-1:0] STEP = 32'h9E3779B9;
  localparam int unsigned EW   = 2 * DW + 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [DW-1:0] dataWrite;
  logic          writeEnable;
  logic          strobe;
  logic [DW-1:0] dataRead;
  logic          ready;
  logic          mode;
  logic          displayStep;
  logic [7:0]    bits;
  logic [DW-1:0] signature;
  logic [15:0]   txnCount;
  logic          irqSource;
  logic [IRQW-1:0] interruptReq;
  logic [1:0]    state_dbg;

  debug_bus_responder #(
    .ADDRESS_SIZE(AW), .DATA_SIZE(DW), .WAIT_STATES(WS), .GEN_STEP(STEP), .IRQ_SIZE(IRQW)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .dataWrite(dataWrite),
    .writeEnable(writeEnable), .strobe(strobe), .dataRead(dataRead), .ready(ready),
    .mode(mode), .displayStep(displayStep), .bits(bits), .signature(signature),
    .txnCount(txnCount), .irqSource(irqSource), .interruptReq(interruptReq),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clock = ~clock;

  int check_cnt = 0;
  int pass_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // behavioural reference model
  logic [DW-1:0]   m_gen, m_sig, m_last, m_dr;
  int              m_cnt;
  int              m_idx;
  logic [IRQW-1:0] m_irq;
  logic [EW-1:0]   exp_q[$];

  function automatic logic [DW-1:0] rot8(input logic [DW-1:0] x);
    return (x << 8) | (x >> (DW - 8));
  endfunction

  function automatic logic [7:0] exp_bits();
    logic [DW-1:0] sh;
    sh = m_sig >> (8 * m_idx);
    return ~sh[7:0];
  endfunction

  task automatic model_reset();
    m_gen = '0; m_sig = '0; m_last = '0; m_dr = '0; m_cnt = 0; m_idx = 0;
  endtask

  task automatic model_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic md);
    logic [DW-1:0] a_ext;
    a_ext = DW'(a);
    if (we) begin
      m_sig  = rot8(m_sig) ^ d ^ a_ext;
      m_last = d;
    end else if (md) begin
      m_dr = m_last;
    end else begin
      m_dr  = m_gen ^ a_ext;
      m_gen = rot8(m_gen) + STEP;
    end
    if (m_cnt < 65535) m_cnt++;
    exp_q.push_back({m_dr, m_sig, 16'(m_cnt)});
  endtask

  // monitor / scoreboard
  logic [EW-1:0] mon_e;
  always @(negedge clock) begin
    if (!reset && ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_data", dataRead, mon_e[EW-1 -: DW]);
        chk("signature", signature, mon_e[DW+15 -: DW]);
        chk("txn_count", txnCount, mon_e[15:0]);
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; strobe = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic md, input int hold, input bit drop, input bit scramble);
    int k;
    int extra;
    bit seen;
    @(negedge clock);
    writeEnable = we; address = a; dataWrite = d; mode = md; strobe = 1'b1;
    model_txn(we, a, d, md);
    seen = 1'b0;
    for (k = 1; k <= 64; k++) begin
      @(negedge clock);
      if (ready) begin
        seen = 1'b1;
        break;
      end
      if (drop) strobe = 1'b0;
      if (scramble) begin
        address = AW'($urandom); dataWrite = $urandom;
        writeEnable = 1'($urandom); mode = 1'($urandom);
      end
    end
    chk("ready_latency", seen ? k : 0, WS + 1);
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (ready) extra++;
    end
    chk("single_ready_pulse", extra, 0);
    strobe = 1'b0;
    @(negedge clock);
  endtask

  task automatic pulse_step();
    @(negedge clock);
    displayStep = 1'b1;
    m_idx = (m_idx + 1) % NB;
    repeat (2) @(negedge clock);
    displayStep = 1'b0;
    repeat (2) @(negedge clock);
    chk("led_bits", bits, exp_bits());
  endtask

  initial begin
    int pulses;
    reset = 1'b1; address = '0; dataWrite = '0; writeEnable = 1'b0; strobe = 1'b0;
    mode = 1'b0; displayStep = 1'b0; irqSource = 1'b0;
    model_reset();
    m_irq = '0;
    repeat (3) @(negedge clock);
    chk("reset_ready", ready, 0);
    chk("reset_dataread", dataRead, 0);
    chk("reset_signature", signature, 0);
    chk("reset_txncount", txnCount, 0);
    chk("reset_bits", bits, 8'hFF);
    chk("reset_irq", interruptReq, 0);
    reset = 1'b0;

    // generator reads
    do_txn(1'b0, 15'h0010, '0, 1'b0, 0, 1'b0, 1'b0);
    chk("first_read", dataRead, 32'h00000010);
    do_txn(1'b0, 15'h0000, '0, 1'b0, 0, 1'b0, 1'b1);
    chk("second_read", dataRead, 32'h9E3779B9);

    // signature and LED byte selector
    do_reset();
    do_txn(1'b1, 15'h0004, 32'h12345678, 1'b0, 0, 1'b0, 1'b0);
    chk("sig_first_write", signature, 32'h1234567C);
    repeat (2) @(negedge clock);
    chk("led_bits_idx0", bits, 8'h83);
    for (int i = 0; i < 5; i++) pulse_step();
    @(negedge clock);
    displayStep = 1'b1;
    m_idx = (m_idx + 1) % NB;
    repeat (10) @(negedge clock);
    chk("led_bits_held", bits, exp_bits());
    displayStep = 1'b0;
    do_txn(1'b1, 15'h0000, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    chk("sig_second_write", signature, 32'h34567C12);
    chk("txn_count_two", txnCount, 2);
    repeat (2) @(negedge clock);
    chk("led_bits_after_write", bits, exp_bits());

    // echo mode leaves the generator untouched
    do_reset();
    do_txn(1'b1, 15'h0000, 32'hCAFEBABE, 1'b1, 0, 1'b0, 1'b0);
    do_txn(1'b0, 15'h7FFF, '0, 1'b1, 0, 1'b0, 1'b0);
    chk("echo_read", dataRead, 32'hCAFEBABE);
    do_txn(1'b0, 15'h0000, '0, 1'b0, 0, 1'b0, 1'b0);
    chk("gen_still_zero", dataRead, 32'h0);

    // strobe held after ready, then a fresh request; strobe dropped during wait
    do_txn(1'b0, 15'h0123, '0, 1'b0, 20, 1'b0, 1'b0);
    do_txn(1'b0, 15'h0456, '0, 1'b0, 0, 1'b0, 1'b0);
    do_txn(1'b1, 15'h0042, 32'hA5A5F00F, 1'b0, 0, 1'b1, 1'b1);

    // reset while a transaction waits
    do_reset();
    @(negedge clock);
    writeEnable = 1'b1; address = 15'h0008; dataWrite = 32'hDEADBEEF; strobe = 1'b1;
    @(negedge clock);
    reset = 1'b1; strobe = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (ready) pulses++;
    end
    chk("reset_in_wait_no_ready", pulses, 0);
    chk("reset_in_wait_count", txnCount, 0);
    chk("reset_in_wait_sig", signature, 0);
    chk("reset_in_wait_data", dataRead, 0);
    model_reset();
    do_txn(1'b0, 15'h0010, '0, 1'b0, 0, 1'b0, 1'b0);
    chk("read_after_reset", dataRead, 32'h00000010);

    // interrupt conditioning
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("irq_shift", interruptReq, m_irq);
      irqSource = 1'($urandom);
      m_irq = (m_irq << 1) | IRQW'(irqSource);
    end
    irqSource = 1'b0;

    // randomized transactions
    for (int i = 0; i < 80; i++) begin
      do_txn(1'($urandom), AW'($urandom), $urandom, 1'($urandom),
             $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), 1'($urandom));
    end

    repeat (4) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
